// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: direct-mapped BTB with 2-bit counters, IF prediction and EX mispredict redirect
// Optional: define BRANCH_PERF_CNT_EN to add perf_branches/perf_mispredicts counters.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   if_pc -> if_pred_taken/target     combinational IF lookup
//   ex_*                              resolved branch info and piped prediction from EX
//   redirect_valid/pc, flush_*        same-cycle mispredict recovery
module branch_predict_ctrl #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
`ifdef BRANCH_PERF_CNT_EN
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts,
`endif
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if_id,
    output logic        flush_id_ex
);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit, res, mispredict, upd;
    logic [1:0]       ctr_d;
    logic [31:0]      target_d;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    // Reads use the registered table, so a same-index update this cycle is not visible yet.
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_pred_taken  = if_hit && ctr_q[if_idx][1];
    assign if_pred_target = if_pred_taken ? target_q[if_idx] : if_pc + 32'd4;

    assign res        = ex_valid && ex_is_branch && !ex_stall;
    // rst_n gate keeps recovery outputs quiet while reset is held.
    assign mispredict = rst_n && res &&
                        ((ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_target != ex_target)));

    assign redirect_valid = mispredict;
    assign redirect_pc    = mispredict ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'd0;
    assign flush_if_id    = mispredict;
    assign flush_id_ex    = mispredict;

    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    // A not-taken miss leaves the table alone; everything else writes the indexed entry.
    assign upd    = res && (ex_hit || ex_taken);

    always_comb begin
        ctr_d    = ctr_q[ex_idx];
        target_d = ex_taken ? ex_target : target_q[ex_idx];
        if (!ex_hit)
            ctr_d = 2'b10;
        else if (ex_taken)
            ctr_d = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
        else
            ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= target_d;
            ctr_q[ex_idx]    <= ctr_d;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branches_q, perf_mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            perf_branches_q    <= perf_branches_q + {31'd0, res};
            perf_mispredicts_q <= perf_mispredicts_q + {31'd0, mispredict};
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed and randomized checks of branch_predict_ctrl against a table model
module tb_branch_predict_ctrl;
    localparam int E = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid, ex_stall, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        redirect_valid, flush_if_id, flush_id_ex;
    logic [31:0] redirect_pc;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    bit          mv   [E];
    logic [31:0] mown [E];
    logic [31:0] mtgt [E];
    int          mctr [E];
    int unsigned mb, mm;

    branch_predict_ctrl #(.ENTRIES(E)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
`ifdef BRANCH_PERF_CNT_EN
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
`endif
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 4) % E);
    endfunction

    function automatic bit mhit(input logic [31:0] pc);
        return mv[midx(pc)] && (mown[midx(pc)] / (4 * E) == pc / (4 * E));
    endfunction

    function automatic bit mpt(input logic [31:0] pc);
        return mhit(pc) && mctr[midx(pc)] >= 2;
    endfunction

    function automatic logic [31:0] mptg(input logic [31:0] pc);
        return mpt(pc) ? mtgt[midx(pc)] : pc + 32'd4;
    endfunction

    task automatic mreset();
        for (int i = 0; i < E; i++) begin
            mv[i] = 0; mown[i] = 0; mtgt[i] = 0; mctr[i] = 1;
        end
        mb = 0; mm = 0;
    endtask

    task automatic set_ex(input bit v, input bit st, input bit br, input logic [31:0] pc,
                          input bit tk, input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
        ex_valid = v; ex_stall = st; ex_is_branch = br; ex_pc = pc;
        ex_taken = tk; ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    task automatic idle();
        set_ex(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    // Called just after a negedge with inputs applied; checks, crosses one posedge, returns at the next negedge.
    task automatic cyc();
        bit res, mp;
        int i;
        #2;
        chk("pred_taken", {31'd0, if_pred_taken}, {31'd0, mpt(if_pc)});
        chk("pred_target", if_pred_target, mptg(if_pc));
        res = rst_n && ex_valid && ex_is_branch && !ex_stall;
        mp  = res && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target));
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, mp});
        chk("redirect_pc", redirect_pc, mp ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'd0);
        chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, mp});
        chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, mp});
`ifdef BRANCH_PERF_CNT_EN
        chk("perf_branches", perf_branches, mb);
        chk("perf_mispredicts", perf_mispredicts, mm);
`endif
        @(posedge clk);
        if (res) begin
            i = midx(ex_pc);
            if (mhit(ex_pc)) begin
                if (ex_taken) begin
                    mctr[i] = (mctr[i] < 3) ? mctr[i] + 1 : 3;
                    mtgt[i] = ex_target;
                end else
                    mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
            end else if (ex_taken) begin
                mv[i] = 1; mown[i] = ex_pc; mtgt[i] = ex_target; mctr[i] = 2;
            end
            mb++;
            if (mp) mm++;
        end
        @(negedge clk);
    endtask

    task automatic rand_cycle();
        logic [31:0] pc;
        pc = $urandom_range(0, 127) * 4;
        if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
        if ($urandom_range(0, 1) == 1)
            set_ex($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 80,
                   pc, $urandom_range(0, 1), $urandom_range(0, 255) * 4, mpt(pc), mptg(pc));
        else
            set_ex($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 80,
                   pc, $urandom_range(0, 1), $urandom_range(0, 255) * 4,
                   $urandom_range(0, 1), $urandom_range(0, 255) * 4);
        if_pc = ($urandom_range(0, 9) < 3) ? ex_pc : $urandom_range(0, 127) * 4;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100;
        mreset();
        set_ex(1, 0, 1, 32'h100, 1, 32'h140, 0, 32'h104);
        @(negedge clk);
        #1;
        chk("rst_pred_taken", {31'd0, if_pred_taken}, 32'd0);
        chk("rst_pred_target", if_pred_target, 32'h104);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        chk("idle_pred_target", if_pred_target, 32'h104);
        cyc();

        // First taken resolution mispredicts and allocates.
        set_ex(1, 0, 1, 32'h100, 1, 32'h140, 0, 32'h104);
        #1;
        chk("alloc_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("alloc_redirect_pc", redirect_pc, 32'h140);
        chk("alloc_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
        cyc();
        idle();
        #1;
        chk("alloc_pred_taken", {31'd0, if_pred_taken}, 32'd1);
        chk("alloc_pred_target", if_pred_target, 32'h140);
        cyc();

        repeat (2) begin
            set_ex(1, 0, 1, 32'h100, 1, 32'h140, 1, 32'h140);
            #1;
            chk("correct_no_redirect", {31'd0, redirect_valid}, 32'd0);
            cyc();
        end
        set_ex(1, 0, 1, 32'h100, 0, 32'h140, 1, 32'h140);
        #1;
        chk("nt_redirect_pc", redirect_pc, 32'h104);
        chk("nt_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
        cyc();
        idle();
        #1;
        chk("after_nt_pred_taken", {31'd0, if_pred_taken}, 32'd1);
        cyc();

        // Stalled mispredict: nothing until release, then exactly one update.
        repeat (3) begin
            set_ex(1, 1, 1, 32'h100, 0, 32'h0, 1, 32'h140);
            #1;
            chk("stall_no_redirect", {31'd0, redirect_valid}, 32'd0);
            chk("stall_pred_kept", {31'd0, if_pred_taken}, 32'd1);
            cyc();
        end
        ex_stall = 1'b0;
        #1;
        chk("release_redirect", {31'd0, redirect_valid}, 32'd1);
        cyc();
        idle();
        #1;
        chk("release_pred_nt", {31'd0, if_pred_taken}, 32'd0);
        cyc();

        // Aliasing: 0x140 shares index 0 with 0x100 and replaces it.
        set_ex(1, 0, 1, 32'h100, 1, 32'h180, 0, 32'h104);
        cyc();
        set_ex(1, 0, 1, 32'h140, 1, 32'h1c0, 0, 32'h144);
        cyc();
        idle();
        #1;
        chk("alias_old_miss", {31'd0, if_pred_taken}, 32'd0);
        chk("alias_old_target", if_pred_target, 32'h104);
        cyc();
        if_pc = 32'h140;
        #1;
        chk("alias_new_target", if_pred_target, 32'h1c0);
        cyc();

        // Same-index lookup and update in one cycle: lookup sees the old entry.
        if_pc = 32'h240;
        set_ex(1, 0, 1, 32'h240, 1, 32'h300, 0, 32'h244);
        #1;
        chk("rbw_old_value", if_pred_target, 32'h244);
        cyc();
        idle();
        #1;
        chk("rbw_new_value", if_pred_target, 32'h300);
        cyc();

        if_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_target", if_pred_target, 32'h0);
        cyc();

        repeat (400) rand_cycle();

        // Reset asserted while an allocating mispredict is pending.
        if_pc = 32'h240;
        set_ex(1, 0, 1, 32'h240, 1, 32'h480, 0, 32'h244);
        #1;
        rst_n = 1'b0;
        mreset();
        #1;
        chk("midrst_pred_taken", {31'd0, if_pred_taken}, 32'd0);
        chk("midrst_pred_target", if_pred_target, 32'h244);
        chk("midrst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("midrst_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
`ifdef BRANCH_PERF_CNT_EN
        chk("midrst_perf_br", perf_branches, 32'd0);
        chk("midrst_perf_mp", perf_mispredicts, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        chk("midrst_discarded", {31'd0, if_pred_taken}, 32'd0);
        cyc();

        repeat (200) rand_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
